nts_dispatch_scheduler: RTL and testbench

Shares one `nts_dispatcher` receive buffer between `ENGINES` NTS engines. When the dispatcher reports a complete frame, the block picks an idle engine round-robin, starts the dispatcher FIFO read, and streams every 64-bit word to the chosen engine. After the last word it pulses read/discard to release the buffer. It sits between `nts_dispatcher` and the engine array.

---
 rtl/nts_dispatch_pkg.sv | 15 +
 rtl/nts_rr_arbiter.sv | 26 ++
 rtl/nts_dispatch_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_nts_dispatch_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_dispatch_pkg.sv
// Shared types and widths for the NTS dispatch scheduler.
package nts_dispatch_pkg;
  localparam int WORD_W         = 64;
  localparam int MASK_W         = 8;
  localparam int DEF_ENGINES    = 4;
  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_START   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;
endpackage

// File: rtl/nts_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping.
module nts_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((32'(i_ptr) + 32'(i)) % 32'(N));
      if (!o_valid && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/nts_dispatch_scheduler.sv
// Streams dispatcher frames to a round-robin chosen idle engine (IDLE->SELECT->START->STREAM->DISCARD).
// Optional rd_valid stall watchdog: NTS_DISPATCH_SCHEDULER_WATCHDOG_EN.
module nts_dispatch_scheduler
  import nts_dispatch_pkg::*;
#(
  parameter int ENGINES     = DEF_ENGINES,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_dispatch_packet_available,
  input  logic                  i_dispatch_fifo_empty,
  input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
  input  logic [MASK_W-1:0]     i_dispatch_data_valid,
  output logic                  o_dispatch_fifo_rd_start,
  input  logic                  i_dispatch_fifo_rd_valid,
  input  logic [WORD_W-1:0]     i_dispatch_fifo_rd_data,
  output logic                  o_dispatch_packet_read_discard,
  input  logic [ENGINES-1:0]    i_engine_idle,
  output logic [ENGINES-1:0]    o_engine_wr_en,
  output logic [WORD_W-1:0]     o_engine_wr_data,
  output logic                  o_engine_wr_last,
  output logic [MASK_W-1:0]     o_engine_wr_bytes,
  output logic [31:0]           o_packets,
  output logic [31:0]           o_errors
);
  localparam int PW = $clog2(ENGINES);

  if (ENGINES < 2 || ENGINES > 16 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("nts_dispatch_scheduler: unsupported parameter values");
  end

  state_e                state_q, state_d;
  logic [ENGINES-1:0]    grant_q, grant_d;
  logic [PW-1:0]         gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, next_ptr, gnt_idx;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [MASK_W-1:0]     mask_q, mask_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [ENGINES-1:0]    wr_en_q, wr_en_d;
  logic [WORD_W-1:0]     wr_data_q, wr_data_d;
  logic                  wr_last_q, wr_last_d;
  logic [MASK_W-1:0]     wr_bytes_q, wr_bytes_d;
  logic                  discard_q, discard_d;
  logic [31:0]           packets_q, packets_d;
  logic [ENGINES-1:0]    arb_grant;
  logic                  arb_valid;

  nts_rr_arbiter #(.N(ENGINES)) u_arb (
    .i_req   (i_engine_idle),
    .i_ptr   (rr_ptr_q),
    .o_grant (arb_grant),
    .o_valid (arb_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < ENGINES; i++)
      if (arb_grant[i]) gnt_idx = PW'(i);
  end

  assign next_ptr = (gidx_q == PW'(ENGINES - 1)) ? '0 : gidx_q + 1'b1;

`ifdef NTS_DISPATCH_SCHEDULER_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic [31:0]   errors_q, errors_d;
  logic          wd_fire;

  assign wd_fire = (state_q == ST_STREAM) && !i_dispatch_fifo_rd_valid &&
                   (wdog_q == WW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_q == ST_STREAM && !i_dispatch_fifo_rd_valid) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wdog_q   <= '0;
      errors_q <= '0;
    end else begin
      wdog_q   <= wdog_d;
      errors_q <= errors_d;
    end
  end

  assign o_errors = errors_q;
`else
  assign o_errors = '0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    wcnt_d     = wcnt_q;
    wr_en_d    = '0;
    wr_data_d  = wr_data_q;
    wr_last_d  = 1'b0;
    wr_bytes_d = '0;
    discard_d  = (state_q == ST_DISCARD);
    packets_d  = packets_q;
`ifdef NTS_DISPATCH_SCHEDULER_WATCHDOG_EN
    errors_d   = errors_q;
`endif
    case (state_q)
      // discard_q still high means the dispatcher has not yet dropped the released frame
      ST_IDLE:
        if (i_dispatch_packet_available && !discard_q)
          state_d = i_dispatch_fifo_empty ? ST_DISCARD : ST_SELECT;
      ST_SELECT:
        if (arb_valid) begin
          grant_d = arb_grant;
          gidx_d  = gnt_idx;
          cnt_d   = i_dispatch_counter;
          mask_d  = i_dispatch_data_valid;
          state_d = ST_START;
        end
      ST_START: begin
        wcnt_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM:
        if (i_dispatch_fifo_rd_valid) begin
          wr_en_d    = grant_q;
          wr_data_d  = i_dispatch_fifo_rd_data;
          wr_bytes_d = '1;
          wcnt_d     = wcnt_q + 1'b1;
          if (wcnt_q == {1'b0, cnt_q}) begin
            wr_last_d  = 1'b1;
            wr_bytes_d = mask_q;
            packets_d  = packets_q + 1'b1;
            rr_ptr_d   = next_ptr;
            state_d    = ST_DISCARD;
          end
        end
`ifdef NTS_DISPATCH_SCHEDULER_WATCHDOG_EN
        else if (wd_fire) begin
          wr_en_d    = grant_q;
          wr_data_d  = '0;
          wr_last_d  = 1'b1;
          errors_d   = errors_q + 1'b1;
          rr_ptr_d   = next_ptr;
          state_d    = ST_DISCARD;
        end
`endif
      ST_DISCARD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      wcnt_q     <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_last_q  <= 1'b0;
      wr_bytes_q <= '0;
      discard_q  <= 1'b0;
      packets_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      wcnt_q     <= wcnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_last_q  <= wr_last_d;
      wr_bytes_q <= wr_bytes_d;
      discard_q  <= discard_d;
      packets_q  <= packets_d;
    end
  end

  assign o_dispatch_fifo_rd_start       = (state_q == ST_START);
  assign o_dispatch_packet_read_discard = discard_q;
  assign o_engine_wr_en                 = wr_en_q;
  assign o_engine_wr_data               = wr_data_q;
  assign o_engine_wr_last               = wr_last_q;
  assign o_engine_wr_bytes              = wr_bytes_q;
  assign o_packets                      = packets_q;
endmodule

// File: tb/tb_nts_dispatch_scheduler.sv
// Randomized bench for nts_dispatch_scheduler with a frame-level reference model.
module tb_nts_dispatch_scheduler;
  localparam int E  = 4;
  localparam int AW = 7;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          avail = 1'b0, empty = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0] counter_in = '0;
  logic [7:0]    dv = '0;
  logic [63:0]   rd_data = '0;
  logic [E-1:0]  idle = '0;
  logic          rd_start, discard, wr_last;
  logic [E-1:0]  wr_en;
  logic [63:0]   wr_data;
  logic [7:0]    wr_bytes;
  logic [31:0]   packets, errors;

  always #5 clk = ~clk;

  nts_dispatch_scheduler #(.ENGINES(E), .ADDR_WIDTH(AW), .WDOG_CYCLES(WD)) dut (
    .i_clk                          (clk),
    .i_areset_n                     (rst_n),
    .i_dispatch_packet_available    (avail),
    .i_dispatch_fifo_empty          (empty),
    .i_dispatch_counter             (counter_in),
    .i_dispatch_data_valid          (dv),
    .o_dispatch_fifo_rd_start       (rd_start),
    .i_dispatch_fifo_rd_valid       (rd_valid),
    .i_dispatch_fifo_rd_data        (rd_data),
    .o_dispatch_packet_read_discard (discard),
    .i_engine_idle                  (idle),
    .o_engine_wr_en                 (wr_en),
    .o_engine_wr_data               (wr_data),
    .o_engine_wr_last               (wr_last),
    .o_engine_wr_bytes              (wr_bytes),
    .o_packets                      (packets),
    .o_errors                       (errors)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          eng;
    logic [63:0] data;
    bit          last;
    logic [7:0]  bytes;
    bit          abort;
  } word_t;

  word_t expq[$];
  int    tests = 0, fails = 0;
  int    exp_start = -100, exp_disc_e = -100;
  int    exp_disc = -100, m_packets = 0, m_errors = 0;
  int    strobes[E];
  string       pin_name;
  logic [63:0] pin_act, pin_exp;
  int    pin_seq = 0, pin_done = 0;
  int    m_ptr = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    word_t        w;
    bit           have;
    logic [E-1:0] exp_en;
    have   = 1'b0;
    exp_en = '0;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      w = expq.pop_front();
      have = 1'b1;
      exp_en[w.eng] = 1'b1;
      if (w.last) begin
        exp_disc = cyc + 1;
        if (w.abort) m_errors++;
        else m_packets++;
      end
    end
    chk("wr_en", 64'(wr_en), 64'(exp_en));
    if (have) begin
      if (!w.abort) chk("wr_data", wr_data, w.data);
      chk("wr_bytes", 64'(wr_bytes), 64'(w.bytes));
    end
    chk("wr_last", 64'(wr_last), 64'(have && w.last));
    chk("rd_start", 64'(rd_start), 64'(cyc == exp_start));
    chk("read_discard", 64'(discard), 64'(cyc == exp_disc || cyc == exp_disc_e));
    chk("packets", 64'(packets), 64'(m_packets));
    chk("errors", 64'(errors), 64'(m_errors));
    for (int k = 0; k < E; k++) if (wr_en[k]) strobes[k]++;
    if (pin_seq != pin_done) begin
      chk(pin_name, pin_act, pin_exp);
      pin_done = pin_seq;
    end
  end

  function automatic int first_idle(input logic [E-1:0] idl, input int ptr);
    for (int i = 0; i < E; i++) begin
      int k = (ptr + i) % E;
      if (idl[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [E-1:0] rand_nonzero();
    logic [E-1:0] v;
    do v = E'($urandom); while (v == '0);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string n, input logic [63:0] a, input logic [63:0] e);
    pin_name = n;
    pin_act  = a;
    pin_exp  = e;
    pin_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic noise_drive(input bit noise);
    if (noise) begin
      rd_valid = 1'($urandom);
      rd_data  = {$urandom, $urandom};
    end
  endtask

  task automatic run_frame(input int counter, input logic [7:0] mask, input logic [E-1:0] idle_pre,
                           input int idle_delay, input logic [E-1:0] idle_late,
                           input int stop_after, input bit noise, output int eng);
    int          nw, v, target;
    logic [63:0] d;
    word_t       w;
    avail      = 1'b1;
    empty      = 1'b0;
    counter_in = AW'(counter);
    dv         = mask;
    idle       = idle_pre;
    if (idle_delay == 0) begin
      eng = first_idle(idle_pre, m_ptr);
      exp_start = cyc + 2;
    end else begin
      repeat (idle_delay) begin step(); noise_drive(noise); end
      idle = idle_late;
      eng = first_idle(idle_late, m_ptr);
      exp_start = cyc + 1;
    end
    while (cyc < exp_start) begin step(); noise_drive(noise); end
    step();
    rd_valid   = 1'b0;
    counter_in = AW'($urandom);
    dv         = 8'($urandom);
    idle       = E'($urandom);
    nw = (stop_after >= 0) ? stop_after : counter + 1;
    v = cyc;
    for (int j = 0; j < nw; j++) begin
      repeat ($urandom_range(2, 0)) begin
        rd_valid = 1'b0;
        if ($urandom_range(3, 0) == 0) idle = E'($urandom);
        step();
      end
      d = {$urandom, $urandom};
      rd_valid = 1'b1;
      rd_data  = d;
      w.cyc = cyc + 1; w.eng = eng; w.data = d; w.last = (j == counter);
      w.bytes = (j == counter) ? mask : 8'hff; w.abort = 1'b0;
      expq.push_back(w);
      v = cyc;
      step();
    end
    rd_valid = 1'b0;
    target = v + 1;
    if (stop_after >= 0) begin
      target = v + 1 + WD;
      w.cyc = target; w.eng = eng; w.data = '0; w.last = 1'b1; w.bytes = 8'h00; w.abort = 1'b1;
      expq.push_back(w);
    end
    while (cyc < target + 2) step();
    avail = 1'b0;
    m_ptr = (eng + 1) % E;
  endtask

  task automatic run_empty();
    avail = 1'b1;
    empty = 1'b1;
    exp_disc_e = cyc + 2;
    repeat (3) step();
    avail = 1'b0;
    empty = 1'b0;
  endtask

  initial begin
    int eng, s0, s1, s2, s3, cnt;
    logic [E-1:0] ip, il;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    pin("rst_packets", 64'(packets), 64'd0);

    run_frame(2, 8'hff, 4'b1111, 0, '0, -1, 1'b0, eng);
    pin("t1_grant_model", 64'(eng), 64'd0);
    pin("t1_strobes_e0", 64'(strobes[0]), 64'd3);
    pin("t1_packets", 64'(packets), 64'd1);

    for (int i = 0; i < 4; i++) begin
      run_frame($urandom_range(5, 0), 8'($urandom), 4'b1111, 0, '0, -1, 1'b0, eng);
      pin("t2_grant_model", 64'(eng), 64'((i + 1) % 4));
    end

    s0 = strobes[0]; s1 = strobes[1]; s2 = strobes[2]; s3 = strobes[3];
    run_frame(3, 8'hff, 4'b0000, 20, 4'b0100, -1, 1'b1, eng);
    pin("t3_grant_model", 64'(eng), 64'd2);
    pin("t3_strobes_e0", 64'(strobes[0] - s0), 64'd0);
    pin("t3_strobes_e1", 64'(strobes[1] - s1), 64'd0);
    pin("t3_strobes_e2", 64'(strobes[2] - s2), 64'd4);
    pin("t3_strobes_e3", 64'(strobes[3] - s3), 64'd0);

    s3 = strobes[3];
    run_frame(28, 8'h3f, 4'b1111, 0, '0, -1, 1'b0, eng);
    pin("t4_grant_model", 64'(eng), 64'd3);
    pin("t4_strobes_e3", 64'(strobes[3] - s3), 64'd29);

    run_empty();
    repeat (2) step();
    pin("empty_packets", 64'(packets), 64'd7);

`ifdef NTS_DISPATCH_SCHEDULER_WATCHDOG_EN
    run_frame(10, 8'hff, 4'b1111, 0, '0, 5, 1'b0, eng);
    pin("wd_grant_model", 64'(eng), 64'd0);
    pin("wd_errors", 64'(errors), 64'd1);
    pin("wd_packets", 64'(packets), 64'd7);
    run_frame(2, 8'hff, 4'b1111, 0, '0, -1, 1'b0, eng);
    pin("wd_next_grant_model", 64'(eng), 64'd1);
`endif

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        run_empty();
      end else begin
        cnt = ($urandom_range(9, 0) == 0) ? 127 :
              ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(15, 0);
        il = rand_nonzero();
        if ($urandom_range(2, 0) == 0) begin
          ip = '0;
          run_frame(cnt, 8'($urandom), ip, $urandom_range(5, 1), il, -1, 1'($urandom), eng);
        end else begin
          ip = il;
          run_frame(cnt, 8'($urandom), ip, 0, '0, -1, 1'($urandom), eng);
        end
      end
      repeat ($urandom_range(2, 0)) step();
    end

    repeat (5) step();
    pin("queue_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
